// File: rtl/jtdsp16_do_cache.sv
// DO-loop instruction cache: captures the NI instructions after a DO and replays them K-1 more times.
// Optional redo (DO with NI=0 replays the stored block) enabled by defining JTDSP16_REDO_EN.
module jtdsp16_do_cache #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        do_start,
  input  logic [10:0] do_data,
  input  logic [15:0] rom_dout,
  input  logic        fetch_adv,
  input  logic        ins_start,
  input  logic        ins_long,
  output logic [15:0] cache_dout,
  output logic        cache_sel,
  output logic        pc_hold,
  output logic        loop_busy,
  output logic        fault
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, FILL, REPLAY} state_t;

  state_t          state, state_n;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [AW:0]     len, len_n;
  logic [3:0]      ni_left, ni_left_n;
  logic [6:0]      cnt, cnt_n;
  logic            lat_long, lat_long_n, ovf, ovf_n, fault_n, sel, sel_n;
  logic            we, last_word, last_rd, full;
  logic [3:0]      do_ni;
  logic [6:0]      do_k, k_eff;

  assign do_ni      = do_data[10:7];
  assign do_k       = do_data[6:0];
  assign k_eff      = (do_k == 7'd0) ? 7'd1 : do_k;
  assign full       = (len == (AW+1)'(DEPTH));
  // Final word of the loop body: a short NI-th instruction, or the tail of a long one
  assign last_word  = ins_start ? (ni_left == 4'd1 && !ins_long) : (lat_long && ni_left == 4'd0);
  assign last_rd    = ({1'b0, rd_ptr} == len - 1'b1);

  assign cache_dout = mem[rd_ptr];
  assign cache_sel  = sel;
  assign pc_hold    = sel;
  assign loop_busy  = (state != IDLE);

  always_comb begin
    state_n    = state;
    wr_ptr_n   = wr_ptr;
    rd_ptr_n   = rd_ptr;
    len_n      = len;
    ni_left_n  = ni_left;
    cnt_n      = cnt;
    lat_long_n = lat_long;
    ovf_n      = ovf;
    fault_n    = fault;
    sel_n      = sel;
    we         = 1'b0;
    if (cen) begin
      if (do_start && state != IDLE) fault_n = 1'b1;
      case (state)
        IDLE: if (do_start) begin
          if (do_ni != 4'd0) begin
            ni_left_n  = do_ni;
            cnt_n      = k_eff;
            wr_ptr_n   = '0;
            len_n      = '0;
            ovf_n      = 1'b0;
            lat_long_n = 1'b0;
            state_n    = FILL;
            if (do_k == 7'd0) fault_n = 1'b1;
          end else begin
`ifdef JTDSP16_REDO_EN
            if (len != '0) begin
              cnt_n    = k_eff;
              rd_ptr_n = '0;
              sel_n    = 1'b1;
              state_n  = REPLAY;
            end else begin
              fault_n  = 1'b1;
            end
`else
            fault_n = 1'b1;
`endif
          end
        end
        FILL: if (fetch_adv) begin
          if (full) begin
            fault_n = 1'b1;
            ovf_n   = 1'b1;
          end else begin
            we       = 1'b1;
            wr_ptr_n = wr_ptr + 1'b1;
            len_n    = len + 1'b1;
          end
          if (ins_start) begin
            ni_left_n  = ni_left - 4'd1;
            lat_long_n = ins_long;
          end
          if (last_word) begin
            // An overflowed body is incomplete, so it is never replayed
            if (cnt == 7'd1 || ovf || full) begin
              state_n = IDLE;
            end else begin
              cnt_n    = cnt - 7'd1;
              rd_ptr_n = '0;
              sel_n    = 1'b1;
              state_n  = REPLAY;
            end
          end
        end
        REPLAY: if (fetch_adv) begin
          if (last_rd) begin
            rd_ptr_n = '0;
            if (cnt == 7'd1) begin
              sel_n   = 1'b0;
              state_n = IDLE;
            end else begin
              cnt_n   = cnt - 7'd1;
            end
          end else begin
            rd_ptr_n = rd_ptr + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      len      <= '0;
      ni_left  <= '0;
      cnt      <= '0;
      lat_long <= 1'b0;
      ovf      <= 1'b0;
      fault    <= 1'b0;
      sel      <= 1'b0;
    end else begin
      state    <= state_n;
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      len      <= len_n;
      ni_left  <= ni_left_n;
      cnt      <= cnt_n;
      lat_long <= lat_long_n;
      ovf      <= ovf_n;
      fault    <= fault_n;
      sel      <= sel_n;
    end
  end

  // Storage is not reset so a completed body survives for redo
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= rom_dout;
  end

endmodule

// File: doc/jtdsp16_do_cache.md
Name: jtdsp16_do_cache

Overview:
- DO-loop instruction cache: the consuming end of the instruction decoder's `do_start`/`do_data` interface.
- Captures the NI instruction words that follow a DO, then replays them K-1 more times.
- During replay it supplies words in place of ROM and holds the program counter.
- Sits between program ROM, the XAAU sequencer and the instruction decoder.

Parameters:
- AW, 4, cache address width; depth = 2**AW words (16).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; all state advances only when cen=1
- do_start  in  1  one-cycle DO strobe from the decoder
- do_data  in  11  [10:7]=NI (instruction count), [6:0]=K (iteration count)
- rom_dout  in  16  instruction word currently fetched from ROM
- fetch_adv  in  1  sequencer advanced to a new word this cen cycle (0 while a multi-cycle instruction halts)
- ins_start  in  1  current word is the first word of an instruction
- ins_long  in  1  valid with ins_start; instruction has a second word
- cache_dout  out  16  replay word; mem[rd_ptr], combinational from registered rd_ptr
- cache_sel  out  1  1 = decoder takes cache_dout instead of rom_dout
- pc_hold  out  1  XAAU must not advance PC
- loop_busy  out  1  loop active (FILL or REPLAY); blocks interrupt acceptance
- fault  out  1  sticky protocol error flag

Behaviour:
- Reset (rst_n=0, async): state=IDLE. cache_sel, pc_hold, loop_busy and fault are 0. Pointers, length, ni_left and cnt are 0. Cache contents are not reset.
- States: IDLE, FILL, REPLAY. loop_busy=(state!=IDLE). cache_sel and pc_hold are registered and high only in REPLAY.
- IDLE, on cen & do_start:
  - NI!=0: ni_left=NI; cnt=(K==0)?1:K; wr_ptr=0; len=0; enter FILL. K==0 also sets fault.
  - NI==0 (redo): see Optional Feature.
- FILL, each cen & fetch_adv:
  - mem[wr_ptr]=rom_dout; wr_ptr++; len++.
  - On ins_start: ni_left--; latch ins_long.
  - The last stored word is the final word of the NI-th instruction: the second word if ins_long, otherwise the same word.
  - After storing it: cnt==1 goes to IDLE; otherwise cnt--, rd_ptr=0, go to REPLAY with cache_sel=pc_hold=1 from the next cycle.
  - PC has already advanced to the post-loop word; pc_hold keeps it there.
- FILL overflow: a word arriving with len==2**AW is not stored. fault=1; FILL continues counting instructions and ends in IDLE (no replay).
- REPLAY, each cen & fetch_adv:
  - rd_ptr==len-1: rd_ptr=0. If cnt==1, go to IDLE and drop cache_sel/pc_hold at that edge; otherwise cnt--.
  - Otherwise rd_ptr++.
  - fetch_adv=0 holds rd_ptr, so multi-cycle instructions see a stable word.
- do_start outside IDLE (nesting) sets fault and is otherwise ignored.
- cen=0 freezes everything, including writes.
- len and mem persist after the loop ends, for redo.
- Reset mid-loop returns to IDLE immediately. Outputs drop asynchronously and len clears, so a subsequent redo faults.
- Latency: the first cached word is presented one clock after the final fill word. The loop ends exactly len*(K-1) fetch_adv cycles later.

Optional Feature:
- Macro JTDSP16_REDO_EN.
- Defined: IDLE & do_start with NI==0 and len!=0 sets cnt=(K==0)?1:K, rd_ptr=0 and enters REPLAY directly (cache_sel/pc_hold high next cycle), replaying the stored block cnt times. NI==0 with len==0 sets fault and stays in IDLE.
- Not defined: NI==0 always sets fault and stays in IDLE; no redo logic is synthesised.

Test Plan:
- DO NI=3,K=3, three single-word instructions A,B,C → FILL stores 3 words; cache_sel=1 for 6 fetch cycles emitting A,B,C,A,B,C; pc_hold falls after the 6th; loop_busy high for 9 fetch cycles.
- DO NI=2,K=2 with the first instruction long (ins_long=1) → len=3; replay emits 3 words once; fault=0.
- DO NI=1,K=1 → FILL one word, back to IDLE; cache_sel never asserts.
- Replay with fetch_adv held low 1 cycle mid-loop → cache_dout stable for 2 cycles, total word sequence unchanged.
- DO NI=15,K=2 using 17 words (two long instructions) → fault=1, 16 words stored, returns to IDLE without replay; second do_start during FILL also leaves fault=1.
- With JTDSP16_REDO_EN, after NI=2,K=2 loop of X,Y issue NI=0,K=2 → emits X,Y,X,Y; without the macro → fault=1, no cache_sel; reset mid-REPLAY drops cache_sel immediately.
